// File: rtl/ps_serial_restore.sv
// ps_serial_restore: recovers the minuend i0 = (D + i1) mod 2**size from a
// subtractor result {Br, D} and its subtrahend i1. It adds one bit per clock,
// LSB first, and flags err when the final carry disagrees with Br.
module ps_serial_restore #(
    parameter int unsigned size = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [size-1:0] D,
    input  logic            Br,
    input  logic [size-1:0] i1,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [size-1:0] i0,
    output logic            err
);

    localparam int unsigned CW = $clog2(size + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]      r_state;
    logic [1:0]      w_state_next;
    logic [size-1:0] r_d;
    logic [size-1:0] r_a;
    logic [size-1:0] r_i0;
    logic            r_br;
    logic            r_c;
    logic            r_err;
    logic [CW-1:0]   r_cnt;

    logic            w_s;
    logic            w_c_next;
    logic            w_last;
    logic [size:0]   w_i0_shift;

    // One full-adder slice on the current LSBs plus the running carry
    assign w_s        = r_d[0] ^ r_a[0] ^ r_c;
    assign w_c_next   = (r_d[0] & r_a[0]) | (r_d[0] & r_c) | (r_a[0] & r_c);
    assign w_last     = (r_cnt == CW'(size - 1));
    // Sum bit enters at the MSB so the LSB-first result lands aligned after size shifts
    assign w_i0_shift = {w_s, r_i0};

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = (r_state == S_DONE);
    assign i0        = r_i0;
    assign err       = r_err;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic: accept in IDLE, run size cycles, hold result until taken
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (in_valid)  w_state_next = S_RUN;
            S_RUN:   if (w_last)    w_state_next = S_DONE;
            S_DONE:  if (out_ready) w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // Datapath: operand capture, serial add, result and consistency flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_d   <= '0;
            r_a   <= '0;
            r_i0  <= '0;
            r_br  <= 1'b0;
            r_c   <= 1'b0;
            r_err <= 1'b0;
            r_cnt <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_d   <= D;
                        r_a   <= i1;
                        r_br  <= Br;
                        r_c   <= 1'b0;
                        r_cnt <= '0;
                    end
                end
                S_RUN: begin
                    r_d   <= r_d >> 1;
                    r_a   <= r_a >> 1;
                    r_c   <= w_c_next;
                    r_i0  <= w_i0_shift[size:1];
                    r_cnt <= r_cnt + CW'(1);
                    if (w_last) begin
                        r_err <= w_c_next ^ r_br;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ps_serial_restore.sv
// Bench for ps_serial_restore: three instances (size 1, 4, 8), a driver that
// issues operations and pushes expected results, and a monitor that pops and
// compares whenever an instance hands over a result.
module tb_ps_serial_restore;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // size = 1 instance
    logic       iv1 = 1'b0, ir1, ov1, or1 = 1'b0, br1 = 1'b0, err1;
    logic [0:0] d1 = '0, a1 = '0, i0_1;
    // size = 4 instance
    logic       iv4 = 1'b0, ir4, ov4, or4 = 1'b0, br4 = 1'b0, err4;
    logic [3:0] d4 = '0, a4 = '0, i0_4;
    // size = 8 instance
    logic       iv8 = 1'b0, ir8, ov8, or8 = 1'b0, br8 = 1'b0, err8;
    logic [7:0] d8 = '0, a8 = '0, i0_8;

    ps_serial_restore #(.size(1)) u_dut1 (
        .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(ir1), .D(d1), .Br(br1), .i1(a1),
        .out_valid(ov1), .out_ready(or1), .i0(i0_1), .err(err1));
    ps_serial_restore #(.size(4)) u_dut4 (
        .clk(clk), .rst(rst), .in_valid(iv4), .in_ready(ir4), .D(d4), .Br(br4), .i1(a4),
        .out_valid(ov4), .out_ready(or4), .i0(i0_4), .err(err4));
    ps_serial_restore #(.size(8)) u_dut8 (
        .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .D(d8), .Br(br8), .i1(a8),
        .out_valid(ov8), .out_ready(or8), .i0(i0_8), .err(err8));

    int n_tests = 0;
    int n_fail  = 0;

    // Expected results, encoded as (err << 16) | i0
    int q1[$];
    int q4[$];
    int q8[$];

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int rdy(input int sz);
        case (sz)
            1:       return int'(ir1);
            8:       return int'(ir8);
            default: return int'(ir4);
        endcase
    endfunction

    function automatic int vld(input int sz);
        case (sz)
            1:       return int'(ov1);
            8:       return int'(ov8);
            default: return int'(ov4);
        endcase
    endfunction

    function automatic int res_i0(input int sz);
        case (sz)
            1:       return int'(i0_1);
            8:       return int'(i0_8);
            default: return int'(i0_4);
        endcase
    endfunction

    function automatic int res_err(input int sz);
        case (sz)
            1:       return int'(err1);
            8:       return int'(err8);
            default: return int'(err4);
        endcase
    endfunction

    task automatic drive(input int sz, input logic v, input int d, input int br, input int a);
        case (sz)
            1: begin iv1 = v; d1 = 1'(d); br1 = 1'(br); a1 = 1'(a); end
            8: begin iv8 = v; d8 = 8'(d); br8 = 1'(br); a8 = 8'(a); end
            default: begin iv4 = v; d4 = 4'(d); br4 = 1'(br); a4 = 4'(a); end
        endcase
    endtask

    task automatic set_or(input int sz, input logic v);
        case (sz)
            1:       or1 = v;
            8:       or8 = v;
            default: or4 = v;
        endcase
    endtask

    task automatic push(input int sz, input int e);
        case (sz)
            1:       q1.push_back(e);
            8:       q8.push_back(e);
            default: q4.push_back(e);
        endcase
    endtask

    task automatic drop_last(input int sz);
        case (sz)
            1:       void'(q1.pop_back());
            8:       void'(q8.pop_back());
            default: void'(q4.pop_back());
        endcase
    endtask

    task automatic timeout(input string name);
        n_fail++;
        $display("FAIL %s: timeout waiting on DUT at %0t", name, $time);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1, "bench aborted");
    endtask

    // One operation: reference model is plain modular addition of D and i1;
    // hold = cycles of back-pressure in DONE, rst_at > 0 resets that many cycles into RUN
    task automatic op(input int sz, input int d, input int br, input int a,
                      input int hold, input int rst_at);
        int mask, sum, exp_i0, exp_err, cyc;
        mask    = (1 << sz) - 1;
        sum     = (d & mask) + (a & mask);
        exp_i0  = sum & mask;
        exp_err = (((sum >> sz) & 1) != (br & 1)) ? 1 : 0;
        cyc = 0;
        while (rdy(sz) == 0) begin
            if (cyc > 50) timeout("wait_in_ready");
            @(posedge clk); #1; cyc++;
        end
        drive(sz, 1'b1, d, br, a);
        push(sz, (exp_err << 16) | exp_i0);
        @(posedge clk); #1;
        // Scramble inputs: only the acceptance edge may matter
        drive(sz, 1'b0, int'($urandom), int'($urandom_range(0, 1)), int'($urandom));
        check("in_ready_in_run", rdy(sz), 0);
        if (rst_at > 0) begin
            repeat (rst_at - 1) begin @(posedge clk); #1; end
            rst = 1'b1;
            #1;
            check("rst_i0", res_i0(sz), 0);
            check("rst_err", res_err(sz), 0);
            check("rst_out_valid", vld(sz), 0);
            check("rst_in_ready", rdy(sz), 1);
            drop_last(sz);
            @(posedge clk); #1;
            rst = 1'b0;
            @(posedge clk); #1;
            return;
        end
        cyc = 0;
        while (vld(sz) == 0) begin
            if (cyc > sz + 4) timeout("wait_out_valid");
            @(posedge clk); #1; cyc++;
        end
        check("latency", cyc, sz);
        for (int h = 0; h < hold; h++) begin
            check("hold_i0", res_i0(sz), exp_i0);
            check("hold_err", res_err(sz), exp_err);
            check("hold_out_valid", vld(sz), 1);
            check("hold_in_ready", rdy(sz), 0);
            drive(sz, 1'(h & 1), int'($urandom), int'($urandom_range(0, 1)), int'($urandom));
            @(posedge clk); #1;
        end
        drive(sz, 1'b0, 0, 0, 0);
        check("done_i0", res_i0(sz), exp_i0);
        check("done_err", res_err(sz), exp_err);
        set_or(sz, 1'b1);
        @(posedge clk); #1;
        set_or(sz, 1'b0);
        check("release_out_valid", vld(sz), 0);
        check("release_in_ready", rdy(sz), 1);
    endtask

    // Closed loop through an ideal subtractor: i0r - a gives {Br, D}
    task automatic closed_loop(input int sz, input int n);
        int mask, i0r, a, d, br;
        mask = (1 << sz) - 1;
        for (int k = 0; k < n; k++) begin
            i0r = int'($urandom_range(0, mask));
            a   = int'($urandom_range(0, mask));
            d   = (i0r - a) & mask;
            br  = (i0r < a) ? 1 : 0;
            op(sz, d, br, a, int'($urandom_range(0, 2)), 0);
        end
    endtask

    task automatic mon(input int sz);
        int e;
        if (vld(sz) == 1) begin
            case (sz)
                1: begin if (or1 !== 1'b1) return; end
                8: begin if (or8 !== 1'b1) return; end
                default: begin if (or4 !== 1'b1) return; end
            endcase
            e = -1;
            case (sz)
                1:       if (q1.size() > 0) e = q1.pop_front();
                8:       if (q8.size() > 0) e = q8.pop_front();
                default: if (q4.size() > 0) e = q4.pop_front();
            endcase
            if (e < 0) begin
                check("sb_unexpected_result", 1, 0);
            end else begin
                check("sb_i0", res_i0(sz), e & 16'hFFFF);
                check("sb_err", res_err(sz), e >> 16);
            end
        end
    endtask

    // Monitor: compare each handed-over result against the scoreboard
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                mon(1);
                mon(4);
                mon(8);
            end
        end
    end

    // Driver
    initial begin
        #1;
        check("reset_in_ready", int'(ir4), 1);
        check("reset_out_valid", int'(ov4), 0);
        check("reset_i0", int'(i0_4), 0);
        check("reset_err", int'(err4), 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk); #1;

        op(4, 4'b0101, 0, 4'b0011, 0, 0);
        op(4, 4'b1111, 1, 4'b0001, 0, 0);
        op(4, 4'b1101, 1, 4'b0101, 1, 0);
        op(4, 4'b0001, 1, 4'b0001, 0, 0);
        op(4, 4'b1010, 0, 4'b0110, 5, 0);
        op(4, 4'b0110, 0, 4'b0101, 0, 2);
        op(4, 4'b0111, 0, 4'b0110, 0, 0);
        for (int k = 0; k < 12; k++) begin
            op(4, int'($urandom_range(0, 15)), int'($urandom_range(0, 1)),
               int'($urandom_range(0, 15)), int'($urandom_range(0, 3)), 0);
        end
        closed_loop(4, 16);
        closed_loop(1, 16);
        op(1, 1, 0, 1, 0, 0);
        closed_loop(8, 16);
        op(8, 8'hFF, 0, 8'h01, 2, 0);

        repeat (3) @(posedge clk);
        #1;
        check("sb_drained", q1.size() + q4.size() + q8.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
